// File: rtl/sha3_pad_loader_if.sv
// Bus-side bundle for sha3_pad_loader: the inbound 32-bit message stream
// and the outbound word-addressed RAM write port.
interface sha3_pad_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Stream handshake: a beat transfers on any rising clk edge where
  // s_valid & s_ready are both high; the source holds s_data/s_keep/s_last
  // stable while s_valid is high and s_ready is low.
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH-1:0]   s_data;
  logic [DATA_WIDTH/8-1:0] s_keep;
  logic                    s_last;

  logic                    mem_en;
  logic                    mem_we;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  modport slave (
    input  s_valid, s_data, s_keep, s_last,
    output s_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output s_valid, s_data, s_keep, s_last,
    input  s_ready, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sha3_pad_loader.sv
// Loads a single-block message into the Keccak RAM as one padded SHA3 rate
// block (message, domain byte, zero fill, final 0x80), then starts the core.
module sha3_pad_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RATE_BYTES = 136,
  parameter logic [7:0]            DOMAIN_PAD = 8'h06,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sha3_pad_loader_if.slave        bus,
  output logic                    accel_start,
  input  logic                    accel_done,
  output logic                    busy,
  output logic                    error,
  output logic [7:0]              msg_len
);
  localparam int W   = RATE_BYTES / 4;
  localparam int WCW = $clog2(W);
  localparam logic [WCW-1:0] LAST_W = WCW'(W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, ZERO, START, WAIT_DONE, DRAIN} state_e;

  state_e          state_q;
  logic [WCW-1:0]  wcnt_q;
  logic [7:0]      msg_len_q;
  logic            error_q;
  logic            start_q;

  logic                  fire, at_last_w, keep_full, keep_ok, beat_err, wr;
  logic [2:0]            kcnt;
  logic [7:0]            base_len;
  logic [8:0]            new_len;
  logic [DATA_WIDTH-1:0] last_word, wdata;

  assign bus.s_ready = (state_q == LOAD) || (state_q == DRAIN);
  assign fire        = bus.s_valid && bus.s_ready;
  assign at_last_w   = (wcnt_q == LAST_W);
  assign keep_full   = (bus.s_keep == 4'hF);

  always_comb begin
    keep_ok = 1'b1;
    kcnt    = 3'd0;
    case (bus.s_keep)
      4'h0:    kcnt = 3'd0;
      4'h1:    kcnt = 3'd1;
      4'h3:    kcnt = 3'd2;
      4'h7:    kcnt = 3'd3;
      4'hF:    kcnt = 3'd4;
      default: keep_ok = 1'b0;
    endcase
  end

  // The first beat of a message always lands in word 0, which restarts the count.
  assign base_len = (wcnt_q == '0) ? 8'd0 : msg_len_q;
  assign new_len  = {1'b0, base_len} + {6'd0, kcnt};
  assign beat_err = !keep_ok
                 || (!bus.s_last && !keep_full)
                 || (new_len > 9'(RATE_BYTES - 1))
                 || (bus.s_last && keep_full && at_last_w);

  always_comb begin
    last_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < kcnt)       last_word[8*i +: 8] = bus.s_data[8*i +: 8];
      else if (3'(i) == kcnt) last_word[8*i +: 8] = DOMAIN_PAD;
      else                    last_word[8*i +: 8] = 8'h00;
    end
    if (at_last_w) last_word[31:24] = last_word[31:24] | 8'h80;
  end

  always_comb begin
    wr    = 1'b0;
    wdata = '0;
    case (state_q)
      LOAD: begin
        wr    = fire && !beat_err;
        wdata = bus.s_last ? last_word : bus.s_data;
      end
      PAD: begin
        wr    = 1'b1;
        wdata = {24'h0, DOMAIN_PAD} | (at_last_w ? 32'h8000_0000 : 32'h0);
      end
      ZERO: begin
        wr    = 1'b1;
        wdata = at_last_w ? 32'h8000_0000 : 32'h0;
      end
      default: ;
    endcase
  end

  assign bus.mem_en    = wr;
  assign bus.mem_we    = wr;
  assign bus.mem_be    = wr ? 4'hF : 4'h0;
  assign bus.mem_addr  = wr ? BASE_ADDR + ADDR_WIDTH'(wcnt_q) : BASE_ADDR;
  assign bus.mem_wdata = wr ? wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      msg_len_q <= 8'd0;
      error_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (!accel_done) begin
          state_q <= LOAD;
          wcnt_q  <= '0;
        end
        LOAD: if (fire) begin
          // Clean beats clear a stale flag; an erroring beat leaves LOAD.
          error_q <= beat_err;
          if (beat_err) begin
            state_q <= bus.s_last ? IDLE : DRAIN;
          end else begin
            msg_len_q <= new_len[7:0];
            if (!bus.s_last) begin
              wcnt_q <= wcnt_q + WCW'(1);
            end else if (keep_full) begin
              state_q <= PAD;
              wcnt_q  <= wcnt_q + WCW'(1);
            end else if (at_last_w) begin
              state_q <= START;
              start_q <= 1'b1;
            end else begin
              state_q <= ZERO;
              wcnt_q  <= wcnt_q + WCW'(1);
            end
          end
        end
        PAD, ZERO: begin
          if (at_last_w) begin
            state_q <= START;
            start_q <= 1'b1;
          end else begin
            state_q <= ZERO;
            wcnt_q  <= wcnt_q + WCW'(1);
          end
        end
        START:     state_q <= WAIT_DONE;
        WAIT_DONE: if (accel_done) state_q <= IDLE;
        DRAIN:     if (fire && bus.s_last) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign accel_start = start_q;
  assign busy        = (state_q != IDLE);
  assign error       = error_q;
  assign msg_len     = msg_len_q;
endmodule

// File: tb/tb_sha3_pad_loader.sv
// Bench for sha3_pad_loader: random and directed messages, block contents
// predicted from the SHA3 padding rule and checked write-by-write.
module tb_sha3_pad_loader;
  localparam int              AW   = 32;
  localparam int              RB   = 136;
  localparam int              W    = RB / 4;
  localparam logic [7:0]      DP   = 8'h06;
  localparam logic [AW-1:0]   BASE = 32'h0000_0100;

  logic       clk;
  logic       rst_n;
  logic       accel_start;
  logic       accel_done;
  logic       busy;
  logic       error;
  logic [7:0] msg_len;

  sha3_pad_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  sha3_pad_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .RATE_BYTES(RB),
    .DOMAIN_PAD(DP), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .accel_start(accel_start), .accel_done(accel_done),
    .busy(busy), .error(error), .msg_len(msg_len)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  int          start_q[$];
  logic [7:0]  mb[0:RB-1];
  logic [7:0]  blk[0:RB-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en && bus.mem_we) begin
        if (exp_q.size() == 0) fail_now("unexpected_write", {bus.mem_addr, bus.mem_wdata});
        else begin
          check("mem_write", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
          check("mem_be", 64'(bus.mem_be), 64'(4'hF));
        end
      end
      if (accel_start) begin
        if (start_q.size() == 0) fail_now("unexpected_start", 64'(cyc));
        else check("start_cycle", 64'(cyc), 64'(start_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, output int hs);
    int n;
    int g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) begin
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_keep  = k;
    bus.s_last  = l;
    n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) fail_now("handshake_timeout", 64'(n));
    hs = cyc;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
    bus.s_keep  = 4'(($urandom));
    bus.s_last  = 1'b0;
  endtask

  function automatic logic [31:0] raw_word(input int b);
    return {mb[4*b+3], mb[4*b+2], mb[4*b+1], mb[4*b]};
  endfunction

  // Valid message of L bytes: predict the padded block, stream it, run the accelerator.
  task automatic run_msg(input int L, input bit empty_tail, input bit abc);
    int nfull, r, nb, k, hs, n;
    bit tail;
    logic [3:0] keep;
    for (int i = 0; i < RB; i++) mb[i] = 8'($urandom);
    if (abc) begin
      mb[0] = 8'h61; mb[1] = 8'h62; mb[2] = 8'h63; mb[3] = 8'h00;
    end
    for (int i = 0; i < RB; i++) blk[i] = (i < L) ? mb[i] : 8'h00;
    blk[L]    = blk[L] ^ DP;
    blk[RB-1] = blk[RB-1] | 8'h80;
    for (int w = 0; w < W; w++)
      exp_q.push_back({BASE + AW'(w), blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]});

    nfull = L / 4;
    r     = L % 4;
    tail  = !(r == 0 && L > 0 && !empty_tail);
    nb    = nfull + (tail ? 1 : 0);
    k     = tail ? nfull : nfull - 1;
    hs    = 0;
    for (int b = 0; b < nb; b++) begin
      keep = (tail && b == nb - 1) ? 4'((1 << r) - 1) : 4'hF;
      send_beat(raw_word(b), keep, (b == nb - 1), hs);
      if (b == 0) check("error_clear", 64'(error), 64'(0));
    end
    start_q.push_back(hs + W - k);

    n = 0;
    while (start_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (start_q.size() != 0) begin
      fail_now("start_timeout", 64'(L));
      start_q.delete();
    end
    #1;
    repeat ($urandom_range(0, 4)) @(posedge clk);
    #1;
    check("busy_wait", 64'(busy), 64'(1));
    accel_done = 1'b1;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_fall", 64'(busy), 64'(0));
    check("msg_len", 64'(msg_len), 64'(L));
    check("error_ok", 64'(error), 64'(0));
    check("writes_done", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    accel_done = 1'b0;
  endtask

  task automatic finish_error_msg(input string name);
    accel_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_error"}, 64'(error), 64'(1));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_ready"}, 64'(bus.s_ready), 64'(0));
    check({name, "_writes"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    accel_done = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_s_ready"}, 64'(bus.s_ready), 64'(0));
    check({name, "_mem_en"}, 64'(bus.mem_en), 64'(0));
    check({name, "_mem_we"}, 64'(bus.mem_we), 64'(0));
    check({name, "_mem_be"}, 64'(bus.mem_be), 64'(0));
    check({name, "_mem_addr"}, 64'(bus.mem_addr), 64'(BASE));
    check({name, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check({name, "_start"}, 64'(accel_start), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_error"}, 64'(error), 64'(0));
    check({name, "_msg_len"}, 64'(msg_len), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    rst_n       = 1'b0;
    accel_done  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_keep  = '0;
    bus.s_last  = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed padding boundaries
    run_msg(0, 1'b0, 1'b0);
    run_msg(3, 1'b0, 1'b1);
    run_msg(4, 1'b0, 1'b0);
    run_msg(135, 1'b0, 1'b0);
    run_msg(132, 1'b0, 1'b0);
    run_msg(132, 1'b1, 1'b0);
    run_msg(8, 1'b1, 1'b0);

    // random lengths
    for (int t = 0; t < 10; t++)
      run_msg(int'($urandom_range(0, RB - 1)), 1'($urandom_range(0, 1)), 1'b0);

    // 136 bytes: the 34th full beat overflows, the trailing empty beat drains
    for (int i = 0; i < RB; i++) mb[i] = 8'($urandom);
    for (int w = 0; w < W - 1; w++) exp_q.push_back({BASE + AW'(w), raw_word(w)});
    for (int b = 0; b < W; b++) send_beat(raw_word(b), 4'hF, 1'b0, hs);
    send_beat(32'h0, 4'h0, 1'b1, hs);
    finish_error_msg("len136");

    // partial keep on a non-last beat
    for (int i = 0; i < RB; i++) mb[i] = 8'($urandom);
    exp_q.push_back({BASE, raw_word(0)});
    send_beat(raw_word(0), 4'hF, 1'b0, hs);
    send_beat(raw_word(1), 4'h3, 1'b0, hs);
    send_beat(raw_word(2), 4'hF, 1'b0, hs);
    send_beat(raw_word(3), 4'h1, 1'b1, hs);
    finish_error_msg("keep0011");

    // non-contiguous keep on the last beat
    send_beat($urandom, 4'h5, 1'b1, hs);
    finish_error_msg("keep0101");

    run_msg(3, 1'b0, 1'b1);

    // reset mid-LOAD with accel_done held high
    for (int i = 0; i < RB; i++) mb[i] = 8'($urandom);
    for (int w = 0; w < 5; w++) exp_q.push_back({BASE + AW'(w), raw_word(w)});
    for (int b = 0; b < 5; b++) send_beat(raw_word(b), 4'hF, 1'b0, hs);
    check("pre_reset_busy", 64'(busy), 64'(1));
    check("pre_reset_writes", 64'(exp_q.size()), 64'(0));
    accel_done = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("hold_busy", 64'(busy), 64'(0));
    check("hold_ready", 64'(bus.s_ready), 64'(0));
    accel_done = 1'b0;
    run_msg(3, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
